cnt_arbiter: RTL and testbench

Round-robin controller that shares one loadable up-counter (4-bit by default, with sync reset, increment enable and load) between two requesters. Each requester asks for a timed run of `len` ticks. The arbiter grants one requester, preloads the counter, and enables it until terminal count. It then pulses `done` to the owner. It sits between the requesting control logic and the counter's EN/LOAD/load_in/c_out pins.

---
 rtl/cnt_arbiter_if.sv | 26 ++
 rtl/cnt_arbiter.sv | 124 ++++++++++++
 tb/tb_cnt_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cnt_arbiter_if.sv
// Request/grant and counter-pin bundle between cnt_arbiter, its two requesters and the shared counter.
// The master modport is the environment side: requesters plus the counter's c_out.
interface cnt_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic [1:0]       req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [1:0]       grant;
  logic [1:0]       done;
  logic             busy;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_val;

  modport master (
    output req, len0, len1, cnt_val,
    input  grant, done, busy, cnt_load, cnt_load_val, cnt_en
  );

  modport slave (
    input  req, len0, len1, cnt_val,
    output grant, done, busy, cnt_load, cnt_load_val, cnt_en
  );
endinterface

// File: rtl/cnt_arbiter.sv
// Round-robin owner of a shared loadable up-counter: grant, preload TC-len, run to TC, pulse done.
// Define CNT_ARB_ABORT_EN to end a run early when the owner drops its request in LOAD or RUN.
module cnt_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic           CLK,
  input  logic           RST,
  cnt_arbiter_if.slave   bus
);

  localparam logic [WIDTH-1:0] TC = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q,  last_d;
  logic [WIDTH-1:0] len_q,   len_d;

  logic             win_c;
  logic             abort_c;
  logic [1:0]       grant_c;
  logic [1:0]       done_c;
  logic             busy_c;
  logic             load_c;
  logic [WIDTH-1:0] load_val_c;
  logic             en_c;

  // Single requester wins outright; a tie goes to whoever did not own the last run.
  always_comb begin
    unique case (bus.req)
      2'b01:   win_c = 1'b0;
      2'b10:   win_c = 1'b1;
      default: win_c = ~last_q;
    endcase
  end

`ifdef CNT_ARB_ABORT_EN
  assign abort_c = ~bus.req[owner_q];
`else
  assign abort_c = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    len_d      = len_q;
    grant_c    = 2'b00;
    done_c     = 2'b00;
    busy_c     = 1'b0;
    load_c     = 1'b0;
    load_val_c = '0;
    en_c       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          owner_d = win_c;
          len_d   = win_c ? bus.len1 : bus.len0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        busy_c     = 1'b1;
        grant_c    = owner_q ? 2'b10 : 2'b01;
        load_c     = 1'b1;
        load_val_c = TC - len_q;
        if (abort_c) begin
          last_d  = owner_q;
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy_c  = 1'b1;
        grant_c = owner_q ? 2'b10 : 2'b01;
        en_c    = (bus.cnt_val != TC);
        if (abort_c) begin
          last_d  = owner_q;
          state_d = S_IDLE;
        end else if (bus.cnt_val == TC) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_c  = 1'b1;
        grant_c = owner_q ? 2'b10 : 2'b01;
        done_c  = owner_q ? 2'b10 : 2'b01;
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.grant        = grant_c;
  assign bus.done         = done_c;
  assign bus.busy         = busy_c;
  assign bus.cnt_load     = load_c;
  assign bus.cnt_load_val = load_val_c;
  assign bus.cnt_en       = en_c;

endmodule

// File: tb/tb_cnt_arbiter.sv
// Directed bench for cnt_arbiter with a behavioural model of the shared counter.
// Honours CNT_ARB_ABORT_EN the same way as the design.
module tb_cnt_arbiter;

  localparam int unsigned W  = 4;
  localparam int unsigned NV = 18;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [W-1:0] cnt_q;
  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_on = 1'b0;

  cnt_arbiter_if #(.WIDTH(W)) bus ();

  cnt_arbiter #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Counter model: sync reset, load has priority over enable.
  always_ff @(posedge CLK) begin
    if (RST)               cnt_q <= '0;
    else if (bus.cnt_load) cnt_q <= bus.cnt_load_val;
    else if (bus.cnt_en)   cnt_q <= cnt_q + W'(1);
  end
  assign bus.cnt_val = cnt_q;

  typedef struct packed {
    logic         rst;
    logic [1:0]   req;
    logic [W-1:0] len0;
    logic [W-1:0] len1;
    logic [10:0]  exp;
  } vec_t;

  vec_t tbl [NV];

  function automatic logic [10:0] ov(input logic [1:0] g, input logic [1:0] d, input logic b,
                                     input logic l, input logic [W-1:0] lv, input logic e);
    return {g, d, b, l, lv, e};
  endfunction

  function automatic vec_t vec(input logic r, input logic [1:0] q, input logic [W-1:0] l0,
                               input logic [W-1:0] l1, input logic [10:0] e);
    vec_t v;
    v.rst = r; v.req = q; v.len0 = l0; v.len1 = l1; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [10:0] e);
    logic [10:0] got;
    got = {bus.grant, bus.done, bus.busy, bus.cnt_load, bus.cnt_load_val, bus.cnt_en};
    n_cmp++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got {grant,done,busy,load,val,en}=%b_%b_%b_%b_%h_%b expected %b_%b_%b_%b_%h_%b",
               nm, got[10:9], got[8:7], got[6], got[5], got[4:1], got[0],
               e[10:9], e[8:7], e[6], e[5], e[4:1], e[0]);
    end
  endtask

  task automatic cyc(input string nm, input logic [10:0] e);
    @(negedge CLK);
    chk(nm, e);
  endtask

  // Exclusivity holds every cycle once out of the initial unknown state.
  always @(negedge CLK) begin
    if (mon_on) begin
      n_cmp++;
      if ((bus.cnt_load && bus.cnt_en) || !$onehot0(bus.grant) || !$onehot0(bus.done)) begin
        n_fail++;
        $display("FAIL excl: got load=%b en=%b grant=%b done=%b expected exclusive",
                 bus.cnt_load, bus.cnt_en, bus.grant, bus.done);
      end
    end
  end

  initial begin
    logic [1:0] g;
    bus.req  = 2'b00;
    bus.len0 = '0;
    bus.len1 = '0;

    tbl[0]  = vec(1'b1, 2'b00, 4'd0, 4'd0, ov(2'b00, 2'b00, 0, 0, 4'd0,  0));
    tbl[1]  = vec(1'b0, 2'b00, 4'd0, 4'd0, ov(2'b00, 2'b00, 0, 0, 4'd0,  0));
    tbl[2]  = vec(1'b0, 2'b00, 4'd0, 4'd0, ov(2'b00, 2'b00, 0, 0, 4'd0,  0));
    tbl[3]  = vec(1'b0, 2'b01, 4'd5, 4'd0, ov(2'b00, 2'b00, 0, 0, 4'd0,  0));
    tbl[4]  = vec(1'b0, 2'b01, 4'd3, 4'd0, ov(2'b01, 2'b00, 1, 1, 4'd10, 0));
    tbl[5]  = vec(1'b0, 2'b01, 4'd3, 4'd0, ov(2'b01, 2'b00, 1, 0, 4'd0,  1));
    tbl[6]  = vec(1'b0, 2'b01, 4'd3, 4'd0, ov(2'b01, 2'b00, 1, 0, 4'd0,  1));
    tbl[7]  = vec(1'b0, 2'b01, 4'd3, 4'd0, ov(2'b01, 2'b00, 1, 0, 4'd0,  1));
    tbl[8]  = vec(1'b0, 2'b01, 4'd3, 4'd0, ov(2'b01, 2'b00, 1, 0, 4'd0,  1));
    tbl[9]  = vec(1'b0, 2'b01, 4'd3, 4'd0, ov(2'b01, 2'b00, 1, 0, 4'd0,  1));
    tbl[10] = vec(1'b0, 2'b01, 4'd3, 4'd0, ov(2'b01, 2'b00, 1, 0, 4'd0,  0));
    tbl[11] = vec(1'b0, 2'b00, 4'd3, 4'd0, ov(2'b01, 2'b01, 1, 0, 4'd0,  0));
    tbl[12] = vec(1'b0, 2'b00, 4'd3, 4'd0, ov(2'b00, 2'b00, 0, 0, 4'd0,  0));
    tbl[13] = vec(1'b0, 2'b10, 4'd3, 4'd0, ov(2'b00, 2'b00, 0, 0, 4'd0,  0));
    tbl[14] = vec(1'b0, 2'b10, 4'd3, 4'd0, ov(2'b10, 2'b00, 1, 1, 4'd15, 0));
    tbl[15] = vec(1'b0, 2'b10, 4'd3, 4'd0, ov(2'b10, 2'b00, 1, 0, 4'd0,  0));
    tbl[16] = vec(1'b0, 2'b00, 4'd3, 4'd0, ov(2'b10, 2'b10, 1, 0, 4'd0,  0));
    tbl[17] = vec(1'b0, 2'b00, 4'd3, 4'd0, ov(2'b00, 2'b00, 0, 0, 4'd0,  0));

    @(posedge CLK);
    mon_on = 1'b1;

    // Reset, single len=5 run (len change after grant ignored), zero-length run.
    for (int i = 0; i < int'(NV); i++) begin
      @(negedge CLK);
      chk($sformatf("vec%0d", i), tbl[i].exp);
      RST      = tbl[i].rst;
      bus.req  = tbl[i].req;
      bus.len0 = tbl[i].len0;
      bus.len1 = tbl[i].len1;
    end

    // Tie held continuously, len=2: 6-cycle period LOAD,RUN x3,DONE,IDLE; owners alternate.
    bus.req = 2'b11; bus.len0 = 4'd2; bus.len1 = 4'd2;
    for (int k = 1; k <= 24; k++) begin
      g = (((k - 1) / 6) % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge CLK);
      case ((k - 1) % 6)
        0: chk($sformatf("tie_load%0d", k), ov(g, 2'b00, 1, 1, 4'd13, 0));
        1, 2: chk($sformatf("tie_run%0d", k), ov(g, 2'b00, 1, 0, 4'd0, 1));
        3: chk($sformatf("tie_tc%0d", k), ov(g, 2'b00, 1, 0, 4'd0, 0));
        4: chk($sformatf("tie_done%0d", k), ov(g, g, 1, 0, 4'd0, 0));
        default: chk($sformatf("tie_idle%0d", k), ov(2'b00, 2'b00, 0, 0, 4'd0, 0));
      endcase
      if (k == 24) bus.req = 2'b00;
    end

    // Mid-run reset: first make last=0 so the reset's return of last to 1 is observable.
    cyc("mr_idle0", ov(2'b00, 2'b00, 0, 0, 4'd0, 0));  bus.req = 2'b01; bus.len0 = 4'd0;
    cyc("mr_load0", ov(2'b01, 2'b00, 1, 1, 4'd15, 0));
    cyc("mr_run0",  ov(2'b01, 2'b00, 1, 0, 4'd0, 0));
    cyc("mr_done0", ov(2'b01, 2'b01, 1, 0, 4'd0, 0));  bus.req = 2'b00;
    cyc("mr_idle1", ov(2'b00, 2'b00, 0, 0, 4'd0, 0));  bus.req = 2'b01; bus.len0 = 4'd10;
    cyc("mr_load1", ov(2'b01, 2'b00, 1, 1, 4'd5, 0));
    cyc("mr_run1a", ov(2'b01, 2'b00, 1, 0, 4'd0, 1));
    cyc("mr_run1b", ov(2'b01, 2'b00, 1, 0, 4'd0, 1));  RST = 1'b1;
    cyc("mr_rst",   ov(2'b00, 2'b00, 0, 0, 4'd0, 0));  RST = 1'b0; bus.req = 2'b11; bus.len0 = 4'd1;
    cyc("mr_tie_ld",  ov(2'b01, 2'b00, 1, 1, 4'd14, 0));
    cyc("mr_tie_run", ov(2'b01, 2'b00, 1, 0, 4'd0, 1));
    cyc("mr_tie_tc",  ov(2'b01, 2'b00, 1, 0, 4'd0, 0));
    cyc("mr_tie_dn",  ov(2'b01, 2'b01, 1, 0, 4'd0, 0)); bus.req = 2'b00;
    cyc("mr_idle2",   ov(2'b00, 2'b00, 0, 0, 4'd0, 0));

    // Owner 0 drops its request in the third RUN cycle while requester 1 asks.
    bus.req = 2'b01; bus.len0 = 4'd5; bus.len1 = 4'd1;
    cyc("ab_load", ov(2'b01, 2'b00, 1, 1, 4'd10, 0));
    cyc("ab_run1", ov(2'b01, 2'b00, 1, 0, 4'd0, 1));
    cyc("ab_run2", ov(2'b01, 2'b00, 1, 0, 4'd0, 1));
    cyc("ab_run3", ov(2'b01, 2'b00, 1, 0, 4'd0, 1));  bus.req = 2'b10;
`ifdef CNT_ARB_ABORT_EN
    cyc("ab_abort", ov(2'b00, 2'b00, 0, 0, 4'd0, 0));
`else
    cyc("ab_run4",  ov(2'b01, 2'b00, 1, 0, 4'd0, 1));
    cyc("ab_run5",  ov(2'b01, 2'b00, 1, 0, 4'd0, 1));
    cyc("ab_tc",    ov(2'b01, 2'b00, 1, 0, 4'd0, 0));
    cyc("ab_done0", ov(2'b01, 2'b01, 1, 0, 4'd0, 0));
    cyc("ab_idle0", ov(2'b00, 2'b00, 0, 0, 4'd0, 0));
`endif
    cyc("ab_load1", ov(2'b10, 2'b00, 1, 1, 4'd14, 0));
    cyc("ab_run1b", ov(2'b10, 2'b00, 1, 0, 4'd0, 1));
    cyc("ab_tc1",   ov(2'b10, 2'b00, 1, 0, 4'd0, 0));
    cyc("ab_done1", ov(2'b10, 2'b10, 1, 0, 4'd0, 0)); bus.req = 2'b00;
    cyc("ab_idle1", ov(2'b00, 2'b00, 0, 0, 4'd0, 0));
    cyc("ab_idle2", ov(2'b00, 2'b00, 0, 0, 4'd0, 0));

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
